dac_playback_ctrl: RTL
======================

// Module: dac_playback_ctrl
// PURPOSE
//   Sequences waveform playback from a sample RAM into the DAC stream path (x2 width transfer stage).
//   It issues RAM reads and absorbs the RAM read latency in a small FIFO.
//   It honours m_axis_tready, repeats the waveform a configured number of passes and flags DAC-side underruns.
//   Runs entirely in the fast DAC stream clock domain.
// PARAMETERS
//   DWIDTH   128  sample word width (RAM data and stream width)
//   AWIDTH   12   RAM address width
//   RD_LAT   2    RAM read latency, cycles from mem_en to mem_rdata valid (1..4)
//   LOOP_W   16   width of pass counter
// PORTS
//   aclk          in   1        stream clock
//   aresetn       in   1        asynchronous active-low reset
//   start         in   1        1-cycle pulse: begin playback (ignored unless IDLE)
//   stop          in   1        1-cycle pulse: abort playback
//   cfg_len       in   AWIDTH   words per pass (0 = start rejected)
//   cfg_loops     in   LOOP_W   passes to play (0 = infinite)
//   mem_en        out  1        RAM read enable
//   mem_addr      out  AWIDTH   RAM read address
//   mem_rdata     in   DWIDTH   RAM read data, valid RD_LAT cycles after mem_en
//   m_axis_tdata  out  DWIDTH   sample word to DAC transfer stage
//   m_axis_tvalid out  1        word valid
//   m_axis_tready in   1        downstream accept
//   m_axis_tlast  out  1        last word of a pass (address cfg_len-1)
//   busy          out  1        high in any state but IDLE
//   done          out  1        1-cycle pulse on natural completion
//   underrun_cnt  out  16       saturating underrun count
// BEHAVIOUR
//   Reset: state IDLE; mem_en, tvalid, tlast, busy, done = 0; mem_addr, tdata, underrun_cnt = 0; FIFO and in-flight count cleared.
//   States:
//     IDLE   -> RUN on start with cfg_len!=0. cfg_len/cfg_loops are latched then; underrun_cnt is cleared.
//     RUN    issues reads. -> FLUSH on stop. -> FINISH after the final read of the final pass is issued.
//     FINISH -> IDLE when FIFO is empty and in-flight = 0; done pulses that cycle.
//     FLUSH  stops issuing reads, discards landing reads and FIFO contents, holds tvalid=0.
//            -> IDLE once in-flight = 0 (FIFO flushed); no done pulse.
//   FIFO: depth RD_LAT+2; each entry is {tlast, data}.
//   Read issue rule: mem_en=1 in a cycle only if in RUN and fifo_count + inflight < RD_LAT+2. This gives no overflow under any backpressure.
//   Address sequencing:
//     mem_addr starts at 0 and increments per issued read.
//     At cfg_len-1 it wraps to 0 and decrements the remaining-pass counter (unless infinite).
//     That read's entry carries tlast=1.
//   Data path: mem_rdata is pushed into the FIFO RD_LAT cycles after its mem_en.
//     m_axis_tvalid = FIFO not empty, from a registered count; tdata/tlast = FIFO head.
//     Pop on tvalid & tready. Push and pop in the same cycle are both legal.
//   Latency: start in cycle 0 -> first mem_en in cycle 1 -> first tvalid in cycle RD_LAT+2.
//   tvalid, once high, does not drop without a handshake (AXIS rule), except on stop (FLUSH).
//   Underrun: after the first beat of a run, any RUN cycle with tready=1 and tvalid=0 increments underrun_cnt. It saturates at 0xFFFF.
//   Edge cases:
//     start with cfg_len=0: ignored, stays IDLE.
//     start and stop in the same cycle in IDLE: stop wins, stay IDLE.
//     stop in FINISH: go to FLUSH, no done.
//     start while busy: ignored.
//     cfg_len=1: every word has tlast=1.
//     aresetn low mid-run: immediate return to reset values, pending reads discarded.
// TESTING
//   1. cfg_len=4, cfg_loops=2, tready=1 constant, RAM[i]=i.
//      -> tdata 0,1,2,3,0,1,2,3; tlast on beats 4 and 8; first tvalid at cycle RD_LAT+2.
//      -> done pulses once; zero underruns.
//   2. cfg_len=8, cfg_loops=1, tready toggling 1/0 each cycle.
//      -> all 8 words in order, none lost or duplicated; tvalid never drops without a pop.
//      -> fifo_count+inflight never exceeds RD_LAT+2.
//   3. cfg_loops=0 (infinite), cfg_len=3, then stop after 20 beats.
//      -> tvalid=0 the cycle after stop; busy falls once in-flight drains; no done pulse.
//   4. Stall the RAM by forcing tready=0 for 10 cycles, then 1, in RUN after the first beat.
//      -> underrun_cnt unchanged (tready=0 is not an underrun).
//      -> Force FIFO empty with tready=1 for 3 cycles -> underrun_cnt = 3.
//   5. start with cfg_len=0 -> busy stays 0, no mem_en.
//      start+stop in the same cycle -> no activity.
//      start while busy -> no restart, sequence unaffected.
//   6. aresetn asserted mid-pass with reads in flight -> all outputs at reset values immediately.
//      -> After release, a new start replays from address 0 cleanly.

Source files
------------

// File: rtl/dac_playback_ctrl.sv
// Waveform playback sequencer: streams sample RAM words to the DAC transfer stage,
// hiding RAM read latency behind a small credit-limited FIFO.
module dac_playback_ctrl #(
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 12,
  parameter int RD_LAT = 2,
  parameter int LOOP_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              stop,
  input  logic [AWIDTH-1:0] cfg_len,
  input  logic [LOOP_W-1:0] cfg_loops,
  output logic              mem_en,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [15:0]       underrun_cnt
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0] ROOM = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [AWIDTH-1:0]   len_q;
  logic [LOOP_W-1:0]   passes_left;
  logic                infinite;
  logic [RD_LAT-1:0]   rd_vld, rd_last;
  logic [CW-1:0]       fifo_count, inflight;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [DWIDTH-1:0]   fifo_data [DEPTH];
  logic [DEPTH-1:0]    fifo_last;
  logic                seen_beat;
  logic                accept, flush_now, wrap, final_rd, land, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept    = (state == IDLE) && start && !stop && (cfg_len != '0);
  assign flush_now = stop && ((state == RUN) || (state == FINISH));
  // Credits count every word already requested but not yet popped, so the FIFO can never overflow.
  assign mem_en    = (state == RUN) && !stop &&
                     (({1'b0, fifo_count} + {1'b0, inflight}) < ROOM);
  assign wrap      = (mem_addr == len_q - 1'b1);
  assign final_rd  = mem_en && wrap && !infinite && (passes_left == LOOP_W'(1));
  assign land      = rd_vld[RD_LAT-1];
  assign push      = land && (state != FLUSH) && !flush_now;

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tlast  = fifo_last[rd_ptr];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign busy          = (state != IDLE);
  assign done          = (state == FINISH) && !stop && (fifo_count == '0) && (inflight == '0);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: next state is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (stop) state_nxt = FLUSH;
               else if (final_rd) state_nxt = FINISH;
      FINISH:  if (stop) state_nxt = FLUSH;
               else if ((fifo_count == '0) && (inflight == '0)) state_nxt = IDLE;
      FLUSH:   if (inflight == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_q       <= '0;
      passes_left <= '0;
      infinite    <= 1'b0;
      mem_addr    <= '0;
    end else if (accept) begin
      len_q       <= cfg_len;
      passes_left <= cfg_loops;
      infinite    <= (cfg_loops == '0);
      mem_addr    <= '0;
    end else if (mem_en) begin
      if (wrap) begin
        mem_addr <= '0;
        if (!infinite) passes_left <= passes_left - 1'b1;
      end else begin
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end

  // Read-latency shadow: one valid/tlast tag per outstanding RAM read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_vld   <= '0;
      rd_last  <= '0;
      inflight <= '0;
    end else begin
      rd_vld  <= RD_LAT'({rd_vld, mem_en});
      rd_last <= RD_LAT'({rd_last, wrap});
      case ({mem_en, land})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // NOTE: the FIFO storage is reset because it is only a few words deep and tdata must read 0 out of reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) fifo_data[i] <= '0;
      fifo_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush_now) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_last[wr_ptr] <= rd_last[RD_LAT-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Underruns only count once the DAC has seen real data in this run.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      seen_beat    <= 1'b0;
      underrun_cnt <= '0;
    end else if (accept) begin
      seen_beat    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (pop) seen_beat <= 1'b1;
      if ((state == RUN) && seen_beat && m_axis_tready && !m_axis_tvalid &&
          (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule
